// File: rtl/alu_seq_pkg.sv
// Shared opcode and state encodings for the ALU operation sequencer.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL_RST,
        MUL_WAIT,
        DONE
    } state_e;

    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd10;

endpackage

// File: rtl/alu_result_sel.sv
// Selects the ALU output and carry/overflow for the registered opcode and
// derives zero/negative/error; error responses are forced to a zero result.
module alu_result_sel
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [3:0]   op_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] sum_i,
    input  logic [N-1:0] diff_i,
    input  logic [N-1:0] quot_i,
    input  logic [N-1:0] mod_i,
    input  logic [N-1:0] and_i,
    input  logic [N-1:0] or_i,
    input  logic [N-1:0] xor_i,
    input  logic [N-1:0] shl_i,
    input  logic [N-1:0] shr_i,
    input  logic [N-1:0] mult_i,
    input  logic         sum_c_i,
    input  logic         sum_v_i,
    input  logic         sub_c_i,
    input  logic         sub_v_i,
    input  logic         mul_c_i,
    input  logic         mul_v_i,
    output logic [N-1:0] result_o,
    output logic         z_o,
    output logic         n_o,
    output logic         c_o,
    output logic         v_o,
    output logic         err_o
);

    logic [N-1:0] res;
    logic         c;
    logic         v;
    logic         err;
    logic         b_zero;

    assign b_zero = (b_i == '0);

    // Error arms leave res/c/v at their zero defaults.
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        err = 1'b0;
        case (op_i)
            OP_ADD: begin res = sum_i;  c = sum_c_i; v = sum_v_i; end
            OP_SUB: begin res = diff_i; c = sub_c_i; v = sub_v_i; end
            OP_MUL: begin res = mult_i; c = mul_c_i; v = mul_v_i; end
            OP_DIV: begin
                if (b_zero) err = 1'b1;
                else        res = quot_i;
            end
            OP_MOD: begin
                if (b_zero) err = 1'b1;
                else        res = mod_i;
            end
            OP_AND: res = and_i;
            OP_OR:  res = or_i;
            OP_XOR: res = xor_i;
            OP_SHL: res = shl_i;
            OP_SHR: res = shr_i;
            default: err = 1'b1;
        endcase
    end

    assign result_o = res;
    assign z_o      = (res == '0);
    assign n_o      = res[N-1];
    assign c_o      = c;
    assign v_o      = v;
    assign err_o    = err;

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response front end for the ALU: registers operands, sequences the
// multiplier reset and run time, and returns the captured result and flags.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N           = 4,
    parameter int MULT_CYCLES = N + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [N-1:0]       req_a,
    input  logic [N-1:0]       req_b,
    input  logic               req_cin,
    input  logic [$clog2(N):0] req_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [N-1:0]       rsp_result,
    output logic               rsp_z,
    output logic               rsp_n,
    output logic               rsp_c,
    output logic               rsp_v,
    output logic               rsp_err,
    output logic               busy,
    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    output logic               alu_cin,
    output logic [$clog2(N):0] alu_shamt,
    output logic               alu_mult_rst,
    input  logic [N-1:0]       alu_sum,
    input  logic [N-1:0]       alu_diff,
    input  logic [N-1:0]       alu_quot,
    input  logic [N-1:0]       alu_mod,
    input  logic [N-1:0]       alu_and,
    input  logic [N-1:0]       alu_or,
    input  logic [N-1:0]       alu_xor,
    input  logic [N-1:0]       alu_shl,
    input  logic [N-1:0]       alu_shr,
    input  logic [N-1:0]       alu_mult,
    input  logic               alu_sum_c,
    input  logic               alu_sum_v,
    input  logic               alu_sub_c,
    input  logic               alu_sub_v,
    input  logic               alu_mul_c,
    input  logic               alu_mul_v
);

    localparam int CW = $clog2(MULT_CYCLES + 1);
    localparam int RW = N + 5;

    state_e              state_q;
    logic [3:0]          op_q;
    logic [N-1:0]        a_q;
    logic [N-1:0]        b_q;
    logic                cin_q;
    logic [$clog2(N):0]  shamt_q;
    logic [CW-1:0]       cnt_q;
    logic                req_ready_q;
    logic                busy_q;
    logic                mult_rst_q;
    logic                rsp_valid_q;
    logic [RW-1:0]       rsp_q;
    logic [RW-1:0]       rsp_d;

    logic [N-1:0]        sel_result;
    logic                sel_z;
    logic                sel_n;
    logic                sel_c;
    logic                sel_v;
    logic                sel_err;

    alu_result_sel #(.N(N)) u_sel (
        .op_i     (op_q),
        .b_i      (b_q),
        .sum_i    (alu_sum),
        .diff_i   (alu_diff),
        .quot_i   (alu_quot),
        .mod_i    (alu_mod),
        .and_i    (alu_and),
        .or_i     (alu_or),
        .xor_i    (alu_xor),
        .shl_i    (alu_shl),
        .shr_i    (alu_shr),
        .mult_i   (alu_mult),
        .sum_c_i  (alu_sum_c),
        .sum_v_i  (alu_sum_v),
        .sub_c_i  (alu_sub_c),
        .sub_v_i  (alu_sub_v),
        .mul_c_i  (alu_mul_c),
        .mul_v_i  (alu_mul_v),
        .result_o (sel_result),
        .z_o      (sel_z),
        .n_o      (sel_n),
        .c_o      (sel_c),
        .v_o      (sel_v),
        .err_o    (sel_err)
    );

    assign rsp_d = {sel_result, sel_z, sel_n, sel_c, sel_v, sel_err};

    // The multiplier is held in reset everywhere except MUL_WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            shamt_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            mult_rst_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        a_q         <= req_a;
                        b_q         <= req_b;
                        cin_q       <= req_cin;
                        shamt_q     <= req_shamt;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= (req_op == OP_MUL) ? MUL_RST : EXEC;
                    end
                end
                EXEC: begin
                    rsp_q       <= rsp_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                MUL_RST: begin
                    mult_rst_q <= 1'b0;
                    cnt_q      <= CW'(MULT_CYCLES - 1);
                    state_q    <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_q       <= rsp_d;
                        rsp_valid_q <= 1'b1;
                        mult_rst_q  <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_q       <= '0;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    mult_rst_q  <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_q[RW-1 -: N];
    assign rsp_z        = rsp_q[4];
    assign rsp_n        = rsp_q[3];
    assign rsp_c        = rsp_q[2];
    assign rsp_v        = rsp_q[1];
    assign rsp_err      = rsp_q[0];
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_cin      = cin_q;
    assign alu_shamt    = shamt_q;
    assign alu_mult_rst = mult_rst_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU beside it.
module tb_alu_op_sequencer;

    localparam int N    = 4;
    localparam int MC   = N + 1;
    localparam int MASK = (1 << N) - 1;
    localparam int SMAX = (1 << (N - 1)) - 1;
    localparam int SMIN = -(1 << (N - 1));

    typedef struct packed {
        logic [N-1:0] r;
        logic         c;
        logic         v;
    } aluo_t;

    typedef struct {
        logic [N-1:0] res;
        logic z, n, c, v, err;
        int lat;
        int stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [3:0] req_op = '0;
    logic [N-1:0] req_a = '0, req_b = '0;
    logic req_cin = 1'b0;
    logic [2:0] req_shamt = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [N-1:0] rsp_result;
    logic rsp_z, rsp_n, rsp_c, rsp_v, rsp_err, busy;
    logic [N-1:0] alu_a, alu_b;
    logic alu_cin;
    logic [2:0] alu_shamt;
    logic alu_mult_rst;
    logic [N-1:0] alu_sum, alu_diff, alu_quot, alu_mod, alu_and, alu_or;
    logic [N-1:0] alu_xor, alu_shl, alu_shr, alu_mult;
    logic alu_sum_c, alu_sum_v, alu_sub_c, alu_sub_v, alu_mul_c, alu_mul_v;

    int tests = 0, fails = 0;
    int cyc = 0;
    int n_iss = 0, n_rsp = 0;
    int rdy_mode = 0;
    bit seen = 1'b0;
    int mcnt = 0;
    exp_t sb[$];

    alu_op_sequencer #(.N(N), .MULT_CYCLES(MC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_err(rsp_err),
        .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_shamt(alu_shamt), .alu_mult_rst(alu_mult_rst),
        .alu_sum(alu_sum), .alu_diff(alu_diff), .alu_quot(alu_quot), .alu_mod(alu_mod),
        .alu_and(alu_and), .alu_or(alu_or), .alu_xor(alu_xor), .alu_shl(alu_shl),
        .alu_shr(alu_shr), .alu_mult(alu_mult),
        .alu_sum_c(alu_sum_c), .alu_sum_v(alu_sum_v), .alu_sub_c(alu_sub_c),
        .alu_sub_v(alu_sub_v), .alu_mul_c(alu_mul_c), .alu_mul_v(alu_mul_v)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sgn(int x);
        return (x > SMAX) ? x - (1 << N) : x;
    endfunction

    // Arithmetic meaning of each ALU output; div/mod by zero give junk on purpose.
    function automatic aluo_t alu_fn(int op, int a, int b, int cin, int sh);
        aluo_t o;
        int r, s;
        o = '0;
        r = 0;
        case (op)
            0: begin r = a + b + cin; o.c = (r > MASK); s = sgn(a) + sgn(b) + cin;
                     o.v = (s > SMAX || s < SMIN); end
            1: begin r = a - b - cin; o.c = (r < 0); s = sgn(a) - sgn(b) - cin;
                     o.v = (s > SMAX || s < SMIN); end
            2: begin r = a * b; o.c = (r > MASK); s = sgn(a) * sgn(b);
                     o.v = (s > SMAX || s < SMIN); end
            3: r = (b == 0) ? MASK : a / b;
            4: r = (b == 0) ? a : a % b;
            5: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            8: r = (sh >= N) ? 0 : (a << sh);
            9: r = a >> sh;
            default: r = 0;
        endcase
        o.r = N'(r & MASK);
        return o;
    endfunction

    function automatic exp_t ref_model(int op, int a, int b, int cin, int sh);
        exp_t e;
        aluo_t o;
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.err = 1'b0; e.stamp = 0;
        e.lat = (op == 2) ? MC + 2 : 2;
        if (op >= 10 || ((op == 3 || op == 4) && b == 0)) begin
            e.err = 1'b1;
        end else begin
            o = alu_fn(op, a, b, cin, sh);
            e.res = o.r;
            if (op <= 2) begin e.c = o.c; e.v = o.v; end
        end
        e.z = (e.res == 0);
        e.n = e.res[N-1];
        return e;
    endfunction

    // Behavioural ALU; multiplier output is only correct MC cycles after reset release.
    aluo_t f_add, f_sub, f_mul;
    bit mul_ok;
    assign f_add = alu_fn(0, int'(alu_a), int'(alu_b), int'(alu_cin), int'(alu_shamt));
    assign f_sub = alu_fn(1, int'(alu_a), int'(alu_b), int'(alu_cin), int'(alu_shamt));
    assign f_mul = alu_fn(2, int'(alu_a), int'(alu_b), int'(alu_cin), int'(alu_shamt));
    assign mul_ok = !alu_mult_rst && (mcnt >= MC - 1);
    always @(posedge clk) mcnt <= alu_mult_rst ? 0 : mcnt + 1;
    assign alu_sum = f_add.r;  assign alu_sum_c = f_add.c;  assign alu_sum_v = f_add.v;
    assign alu_diff = f_sub.r; assign alu_sub_c = f_sub.c;  assign alu_sub_v = f_sub.v;
    assign alu_mult = mul_ok ? f_mul.r : ~f_mul.r;
    assign alu_mul_c = mul_ok ? f_mul.c : ~f_mul.c;
    assign alu_mul_v = mul_ok ? f_mul.v : ~f_mul.v;
    assign alu_quot = alu_fn(3, int'(alu_a), int'(alu_b), 0, 0).r;
    assign alu_mod  = alu_fn(4, int'(alu_a), int'(alu_b), 0, 0).r;
    assign alu_and  = alu_fn(5, int'(alu_a), int'(alu_b), 0, 0).r;
    assign alu_or   = alu_fn(6, int'(alu_a), int'(alu_b), 0, 0).r;
    assign alu_xor  = alu_fn(7, int'(alu_a), int'(alu_b), 0, 0).r;
    assign alu_shl  = alu_fn(8, int'(alu_a), 0, 0, int'(alu_shamt)).r;
    assign alu_shr  = alu_fn(9, int'(alu_a), 0, 0, int'(alu_shamt)).r;

    task automatic chk(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic issue(int op, int a, int b, int cin, int sh);
        int t = 0;
        exp_t e;
        @(posedge clk); #1;
        req_op = 4'(op); req_a = N'(a); req_b = N'(b); req_cin = 1'(cin);
        req_shamt = 3'(sh); req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && t < 300) begin @(negedge clk); t++; end
        chk("accept_ready", int'(req_ready), 1);
        if (req_ready) begin
            e = ref_model(op, a, b, cin, sh);
            e.stamp = cyc;
            sb.push_back(e);
            n_iss++;
            @(posedge clk);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin @(negedge clk); t++; end
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = ($urandom_range(0, 2) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every cycle a response is presented, pops on handshake.
    initial begin
        int run = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                run = 0;
            end else begin
                if (!alu_mult_rst) run++;
                else if (run > 0) begin chk("mult_rst_low_cycles", run, MC); run = 0; end
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_rsp got=rsp_valid=1 exp=no pending request");
                    end else begin
                        chk("rsp_fields",
                            int'({rsp_result, rsp_z, rsp_n, rsp_c, rsp_v, rsp_err}),
                            int'({sb[0].res, sb[0].z, sb[0].n, sb[0].c, sb[0].v, sb[0].err}));
                        if (!seen) begin
                            chk("latency", cyc - sb[0].stamp, sb[0].lat);
                            seen = 1'b1;
                        end
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            seen = 1'b0;
                            n_rsp++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #2 rst = 1'b0;
        #1;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_mult_rst", int'(alu_mult_rst), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp", int'({rsp_valid, rsp_result, rsp_z, rsp_n, rsp_c, rsp_v, rsp_err}), 0);
        chk("rst_alu_ops", int'({alu_a, alu_b, alu_cin, alu_shamt}), 0);
        #19 rst = 1'b1;

        issue(0, 5, 3, 0, 0);
        issue(2, 5, 2, 0, 0);
        issue(2, 11, 2, 0, 0);
        issue(3, 10, 0, 0, 0);
        issue(4, 7, 2, 0, 0);
        drain();

        issue(15, 1, 1, 0, 0);
        @(negedge clk);
        chk("illegal_ready_exec", int'(req_ready), 0);
        @(negedge clk);
        chk("illegal_ready_done", int'({req_ready, rsp_valid}), 1);
        @(negedge clk);
        chk("illegal_ready_after", int'({req_ready, rsp_valid}), 2);
        drain();

        rdy_mode = 2;
        issue(8, 3, 0, 0, 2);
        t = 0;
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        chk("bp_valid", int'(rsp_valid), 1);
        for (int i = 0; i < 4; i++) begin
            req_op = 4'd0; req_valid = 1'b1;
            @(negedge clk);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        req_valid = 1'b0;
        rdy_mode = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!(rsp_valid && rsp_ready) && t < 50);
        @(negedge clk);
        chk("bp_after_consume", int'({req_ready, busy, rsp_valid, rsp_result, rsp_err}), 'h80);
        drain();

        issue(2, 3, 3, 0, 0);
        @(posedge clk); @(posedge clk); #2;
        chk("mid_busy_before", int'({busy, alu_mult_rst}), 2);
        rst = 1'b0;
        #1;
        chk("mid_rst_outs", int'({rsp_valid, rsp_result, rsp_z, rsp_n, rsp_c, rsp_v, rsp_err}), 0);
        chk("mid_rst_ctrl", int'({busy, alu_mult_rst, req_ready}), 3);
        n_iss -= sb.size();
        sb.delete();
        seen = 1'b0;
        @(negedge clk); #3 rst = 1'b1;
        issue(7, 5, 9, 0, 0);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int op, b;
            op = $urandom_range(0, 12);
            b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, MASK);
            issue(op, $urandom_range(0, MASK), b, $urandom_range(0, 1), $urandom_range(0, 7));
        end
        drain();
        rdy_mode = 0;
        @(negedge clk); @(negedge clk);
        chk("resp_count", n_rsp, n_iss);
        chk("end_idle", int'({busy, req_ready}), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
